// File: rtl/pio_input_debouncer_pkg.sv
// Shared constants for the PIO input conditioning blocks.
//   - Default parameter values for the switch and button instances.
//   - Invert masks for the board switch and button banks.
//   - Width helpers for the debounce counter and the tick prescaler.
package pio_cond_pkg;

  localparam int DEFAULT_WIDTH          = 32;
  localparam int DEFAULT_SYNC_STAGES    = 2;
  localparam int DEFAULT_TICK_DIV       = 50000;
  localparam int DEFAULT_DEBOUNCE_TICKS = 10;

  // Switches are active-high; the four push buttons are active-low.
  localparam logic [31:0] SWITCH_INVERT_MASK = 32'h0000_0000;
  localparam logic [31:0] BUTTON_INVERT_MASK = 32'h0000_000F;

  // Counter runs 0..ticks-1; one spare bit keeps ticks=1 legal.
  function automatic int cnt_width(input int ticks);
    return $clog2(ticks) + 1;
  endfunction

  function automatic int presc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  localparam int DEFAULT_CNT_W   = cnt_width(DEFAULT_DEBOUNCE_TICKS);
  localparam int DEFAULT_PRESC_W = presc_width(DEFAULT_TICK_DIV);

endpackage

// File: rtl/pio_input_debouncer_bit.sv
// One input bit of the conditioning stage: polarity inversion, a
// SYNC_STAGES-deep synchroniser, a tick-qualified debounce counter and the
// registered rise/fall event pulses.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   raw        : unsynchronised board input
//   tick       : debounce time base, one cycle per tick
//   clean      : debounced level
//   rise, fall : one-cycle pulses, same cycle that clean changes
module debounce_bit
  import pio_cond_pkg::*;
#(
  parameter int   SYNC_STAGES    = DEFAULT_SYNC_STAGES,
  parameter int   DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
  parameter logic INVERT         = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic tick,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   sync_bit;
  logic [CNT_W-1:0]       cnt;

  // Synchroniser stage: inversion happens before the first flop so the
  // chain only ever carries the active-high view of the input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], raw ^ INVERT};
    end
  end

  assign sync_bit = sync_p[SYNC_STAGES-1];

  // Debounce stage: any sample matching the stable level discards the
  // partial count, so only an unbroken run of differing ticks is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clean <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync_bit == clean) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CNT_LAST) begin
          clean <= sync_bit;
          cnt   <= '0;
          rise  <= sync_bit;
          fall  <= ~sync_bit;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pio_input_debouncer.sv
// Input conditioning for a 32-bit PIO bank (switches or buttons).
// Synchronises, debounces and optionally inverts each raw board input and
// reports accepted level changes as one-cycle event pulses.
// Ports:
//   clk        : system clock
//   reset      : asynchronous active-high reset
//   raw_in     : unsynchronised board inputs
//   clean_out  : debounced level word for the PIO export
//   rise_pulse : per-bit pulse on an accepted 0->1 change
//   fall_pulse : per-bit pulse on an accepted 1->0 change
//   any_change : OR of all rise and fall pulses, same cycle
module pio_input_debouncer
  import pio_cond_pkg::*;
#(
  parameter int               WIDTH          = DEFAULT_WIDTH,
  parameter int               SYNC_STAGES    = DEFAULT_SYNC_STAGES,
  parameter int               TICK_DIV       = DEFAULT_TICK_DIV,
  parameter int               DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS,
  parameter logic [WIDTH-1:0] INVERT_MASK    = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] clean_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);

  logic tick;

  // Tick stage: one shared prescaler paces every bit's counter.
  generate
    if (TICK_DIV <= 1) begin : g_tick_always
      assign tick = 1'b1;
    end else begin : g_presc
      localparam int                 PRESC_W    = presc_width(TICK_DIV);
      localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

      logic [PRESC_W-1:0] presc;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          presc <= '0;
        end else if (presc == PRESC_LAST) begin
          presc <= '0;
        end else begin
          presc <= presc + 1'b1;
        end
      end

      assign tick = (presc == PRESC_LAST);
    end
  endgenerate

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
        .SYNC_STAGES   (SYNC_STAGES),
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
        .INVERT        (INVERT_MASK[i])
      ) u_bit (
        .clk  (clk),
        .reset(reset),
        .raw  (raw_in[i]),
        .tick (tick),
        .clean(clean_out[i]),
        .rise (rise_pulse[i]),
        .fall (fall_pulse[i])
      );
    end
  endgenerate

  // Pulses are already registered, so the OR lines up with them.
  assign any_change = |(rise_pulse | fall_pulse);

endmodule
